// File: rtl/stream_mux_arb_pkg.sv
// Shared definitions for the stream multiplexer/arbiter: selection modes,
// output register states and a width helper.
package stream_mux_arb_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'b00,
    MODE_RR     = 2'b01,
    MODE_FORCED = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_e;

  // Number of bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational arbiter: one-hot grant plus granted index from per-channel
// requests under fixed-priority, round-robin or forced selection.
module rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    sel,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_vld
);

  // Channel visited at step k of the round-robin scan, wrapping at CHANNELS
  // rather than at a power of two.
  function automatic int rr_slot(input int base, input int k);
    int c;
    c = base + k;
    return (c >= CHANNELS) ? c - CHANNELS : c;
  endfunction

  int base;

  always_comb begin
    base = (int'(ptr) < CHANNELS) ? int'(ptr) : 0;
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    case (mode)
      MODE_RR: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (!grant_vld && req[rr_slot(base, k)]) begin
            grant_vld                  = 1'b1;
            grant_idx                  = SEL_W'(rr_slot(base, k));
            grant[rr_slot(base, k)]    = 1'b1;
          end
        end
      end
      MODE_FORCED: begin
        // An out-of-range sel matches no channel and so yields no grant.
        for (int i = 0; i < CHANNELS; i++) begin
          if (sel == SEL_W'(i) && req[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(i);
            grant[i]  = 1'b1;
          end
        end
      end
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!grant_vld && req[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(i);
            grant[i]  = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage and run-time selectable arbitration policy.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  ostate_e             state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_W-1:0]    chan_q, chan_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_vld;
  logic                load_en;
  logic                xfer;
  logic [WIDTH-1:0]    sel_word;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .mode      (mode),
    .sel       (sel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // out_ready feeds in_ready combinationally; there is no skid buffer.
  // No handshake is offered while reset is held.
  assign load_en  = (state_q == ST_EMPTY) || out_ready;
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign xfer     = load_en && grant_vld;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) sel_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    chan_d   = chan_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d = ST_FULL;
      data_d  = sel_word;
      chan_d  = grant_idx;
      if (mode == MODE_RR) begin
        rr_ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (load_en) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      chan_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: a 4-channel instance driven from a
// vector table and a 3-channel instance for non-power-of-two corner cases.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst_n;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;

  // 3-channel instance
  logic        r3_rst_n;
  logic [1:0]  r3_mode;
  logic [1:0]  r3_sel;
  logic [2:0]  r3_in_valid;
  logic [23:0] r3_in_data;
  logic [2:0]  r3_in_ready;
  logic        r3_out_valid;
  logic [7:0]  r3_out_data;
  logic [1:0]  r3_out_chan;
  logic        r3_out_ready;

  stream_mux_arb #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  stream_mux_arb #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(r3_rst_n), .mode(r3_mode), .sel(r3_sel),
    .in_valid(r3_in_valid), .in_data(r3_in_data), .in_ready(r3_in_ready),
    .out_valid(r3_out_valid), .out_data(r3_out_data), .out_chan(r3_out_chan),
    .out_ready(r3_out_ready)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // ch3..ch0 data words
  localparam logic [31:0] D0 = 32'h33_22_11_44;
  localparam logic [31:0] D1 = 32'h33_22_5A_44;

  function automatic vec_t mk(input logic r, input logic [1:0] m, input logic [1:0] s,
                              input logic [3:0] iv, input logic [31:0] d, input logic ordy,
                              input logic [3:0] ir, input logic ov, input logic [7:0] od,
                              input logic [1:0] oc);
    vec_t v;
    v.rst_n = r; v.mode = m; v.sel = s; v.iv = iv; v.data = d; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_oc = oc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step3(input int idx, input logic r, input logic [1:0] m, input logic [1:0] s,
                       input logic [2:0] iv, input logic ordy, input logic [2:0] ir,
                       input logic ov, input logic [7:0] od, input logic [1:0] oc,
                       input logic chk_data);
    r3_rst_n = r; r3_mode = m; r3_sel = s; r3_in_valid = iv; r3_out_ready = ordy;
    #1;
    check("c3_in_ready", idx, {29'd0, r3_in_ready}, {29'd0, ir});
    @(posedge clk);
    #1;
    check("c3_out_valid", idx, {31'd0, r3_out_valid}, {31'd0, ov});
    if (chk_data) begin
      check("c3_out_data", idx, {24'd0, r3_out_data}, {24'd0, od});
      check("c3_out_chan", idx, {30'd0, r3_out_chan}, {30'd0, oc});
    end
  endtask

  initial begin
    r3_rst_n = 1'b0; r3_mode = 2'b00; r3_sel = 2'd0; r3_in_valid = 3'b000;
    r3_in_data = 24'hC2_B1_A0; r3_out_ready = 1'b1;

    // reset held with all channels valid
    vecs.push_back(mk(0, 2'b00, 2'd0, 4'b1111, D0, 1, 4'b0000, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 2'b00, 2'd0, 4'b1111, D0, 1, 4'b0000, 0, 8'h00, 2'd0));
    vecs.push_back(mk(1, 2'b00, 2'd0, 4'b1111, D0, 1, 4'b0001, 1, 8'h44, 2'd0));
    // fixed priority
    vecs.push_back(mk(1, 2'b00, 2'd0, 4'b1010, D0, 1, 4'b0010, 1, 8'h11, 2'd1));
    vecs.push_back(mk(1, 2'b00, 2'd0, 4'b1010, D0, 1, 4'b0010, 1, 8'h11, 2'd1));
    vecs.push_back(mk(1, 2'b00, 2'd0, 4'b1000, D0, 1, 4'b1000, 1, 8'h33, 2'd3));
    vecs.push_back(mk(1, 2'b00, 2'd0, 4'b0000, D0, 1, 4'b0000, 0, 8'h00, 2'd0));
    // round-robin, all valid, pointer starts at 0
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D0, 1, 4'b0001, 1, 8'h44, 2'd0));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D0, 1, 4'b0010, 1, 8'h11, 2'd1));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D0, 1, 4'b0100, 1, 8'h22, 2'd2));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D0, 1, 4'b1000, 1, 8'h33, 2'd3));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D0, 1, 4'b0001, 1, 8'h44, 2'd0));
    // backpressure on 0x5A; pointer must not move while stalled
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D1, 1, 4'b0010, 1, 8'h5A, 2'd1));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D1, 0, 4'b0000, 1, 8'h5A, 2'd1));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D1, 0, 4'b0000, 1, 8'h5A, 2'd1));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D1, 0, 4'b0000, 1, 8'h5A, 2'd1));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D1, 1, 4'b0100, 1, 8'h22, 2'd2));
    // forced select
    vecs.push_back(mk(1, 2'b10, 2'd2, 4'b1111, D0, 1, 4'b0100, 1, 8'h22, 2'd2));
    vecs.push_back(mk(1, 2'b10, 2'd2, 4'b1111, D0, 1, 4'b0100, 1, 8'h22, 2'd2));
    vecs.push_back(mk(1, 2'b10, 2'd3, 4'b0111, D0, 1, 4'b0000, 0, 8'h00, 2'd0));
    vecs.push_back(mk(1, 2'b10, 2'd3, 4'b0111, D0, 1, 4'b0000, 0, 8'h00, 2'd0));
    // forced transfers left the pointer at 3
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b1111, D0, 1, 4'b1000, 1, 8'h33, 2'd3));
    // reserved mode acts as fixed and leaves the pointer at 0
    vecs.push_back(mk(1, 2'b11, 2'd0, 4'b0110, D0, 1, 4'b0010, 1, 8'h11, 2'd1));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b0101, D0, 1, 4'b0001, 1, 8'h44, 2'd0));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b0101, D0, 1, 4'b0100, 1, 8'h22, 2'd2));
    vecs.push_back(mk(1, 2'b01, 2'd0, 4'b0101, D0, 1, 4'b0001, 1, 8'h44, 2'd0));
    vecs.push_back(mk(1, 2'b00, 2'd0, 4'b0000, D0, 1, 4'b0000, 0, 8'h00, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; mode = vecs[i].mode; sel = vecs[i].sel;
      in_valid = vecs[i].iv; in_data = vecs[i].data; out_ready = vecs[i].ordy;
      #1;
      check("in_ready", i, {28'd0, in_ready}, {28'd0, vecs[i].exp_ir});
      @(posedge clk);
      #1;
      check("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
      if (!vecs[i].rst_n || vecs[i].exp_ov) begin
        check("out_data", i, {24'd0, out_data}, {24'd0, vecs[i].exp_od});
        check("out_chan", i, {30'd0, out_chan}, {30'd0, vecs[i].exp_oc});
      end
    end

    // 3-channel: out-of-range forced select never grants
    step3(0, 1, 2'b10, 2'd3, 3'b111, 1, 3'b000, 0, 8'h00, 2'd0, 0);
    step3(1, 1, 2'b10, 2'd3, 3'b111, 1, 3'b000, 0, 8'h00, 2'd0, 0);
    step3(2, 1, 2'b10, 2'd2, 3'b111, 1, 3'b100, 1, 8'hC2, 2'd2, 1);
    // round-robin wraps at 3
    step3(3, 1, 2'b01, 2'd0, 3'b111, 1, 3'b001, 1, 8'hA0, 2'd0, 1);
    step3(4, 1, 2'b01, 2'd0, 3'b111, 1, 3'b010, 1, 8'hB1, 2'd1, 1);
    step3(5, 1, 2'b01, 2'd0, 3'b111, 1, 3'b100, 1, 8'hC2, 2'd2, 1);
    step3(6, 1, 2'b01, 2'd0, 3'b111, 1, 3'b001, 1, 8'hA0, 2'd0, 1);
    // stall FULL, then reset mid-transfer drops the word
    step3(7, 1, 2'b01, 2'd0, 3'b111, 0, 3'b000, 1, 8'hA0, 2'd0, 1);
    step3(8, 0, 2'b01, 2'd0, 3'b111, 0, 3'b000, 0, 8'h00, 2'd0, 1);
    // pointer restarted at channel 0
    step3(9, 1, 2'b01, 2'd0, 3'b111, 1, 3'b001, 1, 8'hA0, 2'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
